// File: rtl/trap_ctrl.sv
// trap_ctrl: commit-stage trap sequencer (IDLE -> FLUSH -> COMMIT -> IDLE) with optional machine timer.
// Latency: event sampled at cycle N, flush_req from N+1, exception_flag one cycle after flush_ack.
// Backpressure: stall stays high while a trap is in flight; FLUSH waits indefinitely for flush_ack.
// Optional feature macro: TIMER_IRQ_EN (internal mtime/mtimecmp; otherwise mtip = ext_timer_irq).

module trap_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [63:0] inst_pc,
  input  logic        exc_illegal,
  input  logic        exc_ebreak,
  input  logic        exc_ecall,
  input  logic        exc_mret,
  input  logic        mstatus_mie,
  input  logic        mie_mtie,
  input  logic        ext_timer_irq,
  input  logic        tmr_wen,
  input  logic [63:0] tmr_wdata,
  input  logic        flush_ack,
  output logic        flush_req,
  output logic        stall,
  output logic        exception_flag,
  output logic [4:0]  exception_cause,
  output logic [63:0] epc,
  output logic        mtip
);

  // Cause encoding: {interrupt bit, 4-bit code}
  localparam logic [4:0] CAUSE_TIMER   = 5'b10111;
  localparam logic [4:0] CAUSE_ILLEGAL = 5'b00010;
  localparam logic [4:0] CAUSE_EBREAK  = 5'b00011;
  localparam logic [4:0] CAUSE_ECALL   = 5'b01011;
  localparam logic [4:0] CAUSE_MRET    = 5'b11111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        timer_hit;
  logic        trap_event;
  logic [4:0]  cause_sel;
  logic [4:0]  cause_q;
  logic [63:0] epc_q;

`ifdef TIMER_IRQ_EN
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        unused_ext_irq;

  // The external pending line has no meaning when the timer is local.
  assign unused_ext_irq = ext_timer_irq;

  // Free-running mtime (wraps naturally) and software-written compare value.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime    <= 64'd0;
      mtimecmp <= {64{1'b1}};
    end else begin
      mtime <= mtime + 64'd1;
      if (tmr_wen) begin
        mtimecmp <= tmr_wdata;
      end
    end
  end

  assign mtip = (mtime >= mtimecmp);
`else
  logic unused_tmr;

  // No local timer: the compare-register write port is dead in this build.
  assign unused_tmr = ^{tmr_wen, tmr_wdata};
  assign mtip       = ext_timer_irq;
`endif

  // An interrupt only counts when both global and timer enables are set.
  assign timer_hit  = mtip & mstatus_mie & mie_mtie;
  assign trap_event = inst_valid &
                      (exc_illegal | exc_ebreak | exc_ecall | exc_mret | timer_hit);

  // Fixed-priority pick of the winning source: timer > illegal > ebreak > ecall > mret.
  always_comb begin
    cause_sel = 5'd0;
    if (timer_hit) begin
      cause_sel = CAUSE_TIMER;
    end else if (exc_illegal) begin
      cause_sel = CAUSE_ILLEGAL;
    end else if (exc_ebreak) begin
      cause_sel = CAUSE_EBREAK;
    end else if (exc_ecall) begin
      cause_sel = CAUSE_ECALL;
    end else if (exc_mret) begin
      cause_sel = CAUSE_MRET;
    end
  end

  // State register; reset aborts any in-flight trap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore outputs; commit-stage inputs are only looked at in IDLE.
  always_comb begin
    state_nxt      = state;
    flush_req      = 1'b0;
    exception_flag = 1'b0;
    stall          = 1'b1;
    case (state)
      IDLE: begin
        stall = 1'b0;
        if (trap_event) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        flush_req = 1'b1;
        if (flush_ack) begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        exception_flag = 1'b1;
        state_nxt      = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Capture cause and PC only on the detect cycle so they stay stable for the CSR file.
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= 5'd0;
      epc_q   <= 64'd0;
    end else if (state == IDLE && trap_event) begin
      cause_q <= cause_sel;
      epc_q   <= inst_pc;
    end
  end

  assign exception_cause = cause_q;
  assign epc             = epc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: table-driven vectors plus hand sequences; scoreboard queue checked on exception_flag.
// Optional feature macro: TIMER_IRQ_EN (adds the mtime/mtimecmp sequence).

module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [63:0] inst_pc;
  logic        exc_illegal, exc_ebreak, exc_ecall, exc_mret;
  logic        mstatus_mie, mie_mtie, ext_timer_irq;
  logic        tmr_wen;
  logic [63:0] tmr_wdata;
  logic        flush_ack;
  logic        flush_req, stall, exception_flag, mtip;
  logic [4:0]  exception_cause;
  logic [63:0] epc;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        vld;
    logic        ill;
    logic        ebk;
    logic        ecl;
    logic        mrt;
    logic        tmr;
    logic        mie;
    logic        mtie;
    logic [63:0] pc;
    int          dly;
    logic        take;
    logic [4:0]  cause;
  } vec_t;

  typedef struct packed {
    logic [4:0]  cause;
    logic [63:0] pc;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[10];
  logic [63:0] model_mtime;

  trap_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .inst_valid      (inst_valid),
    .inst_pc         (inst_pc),
    .exc_illegal     (exc_illegal),
    .exc_ebreak      (exc_ebreak),
    .exc_ecall       (exc_ecall),
    .exc_mret        (exc_mret),
    .mstatus_mie     (mstatus_mie),
    .mie_mtie        (mie_mtie),
    .ext_timer_irq   (ext_timer_irq),
    .tmr_wen         (tmr_wen),
    .tmr_wdata       (tmr_wdata),
    .flush_ack       (flush_ack),
    .flush_req       (flush_req),
    .stall           (stall),
    .exception_flag  (exception_flag),
    .exception_cause (exception_cause),
    .epc             (epc),
    .mtip            (mtip)
  );

  always #5 clk = ~clk;

  // Reference mtime: cleared by reset, +1 every other cycle edge.
  always @(posedge clk) begin
    if (rst) model_mtime <= 64'd0;
    else     model_mtime <= model_mtime + 64'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every exception_flag pulse must match the oldest pending trap.
  always @(negedge clk) begin
    if (!rst && exception_flag === 1'b1) begin
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_flag: cause %0h epc %0h with nothing pending", exception_cause, epc);
      end else begin
        e = sbq.pop_front();
        if (exception_cause !== e.cause || epc !== e.pc) begin
          errors++;
          $display("FAIL sb_trap: got cause %0h epc %0h expected cause %0h epc %0h",
                   exception_cause, epc, e.cause, e.pc);
        end
      end
    end
  end

  task automatic clear_inputs();
    inst_valid    = 1'b0;
    exc_illegal   = 1'b0;
    exc_ebreak    = 1'b0;
    exc_ecall     = 1'b0;
    exc_mret      = 1'b0;
    ext_timer_irq = 1'b0;
    mstatus_mie   = 1'b0;
    mie_mtie      = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts and ends just after a negedge.
  task automatic apply_vec(input vec_t v, input string tag);
    inst_valid    = v.vld;
    exc_illegal   = v.ill;
    exc_ebreak    = v.ebk;
    exc_ecall     = v.ecl;
    exc_mret      = v.mrt;
    ext_timer_irq = v.tmr;
    mstatus_mie   = v.mie;
    mie_mtie      = v.mtie;
    inst_pc       = v.pc;
`ifndef TIMER_IRQ_EN
    check({tag, "_mtip"}, {63'd0, mtip}, {63'd0, v.tmr});
`endif
    if (v.take) sbq.push_back('{cause: v.cause, pc: v.pc});
    cycle();
    clear_inputs();
    inst_pc = 64'hdead_beef_0000_0000;
    if (!v.take) begin
      check({tag, "_no_stall"}, {63'd0, stall}, 64'd0);
      check({tag, "_no_flush"}, {63'd0, flush_req}, 64'd0);
      return;
    end
    check({tag, "_flush_req"}, {63'd0, flush_req}, 64'd1);
    check({tag, "_stall"}, {63'd0, stall}, 64'd1);
    check({tag, "_cause_held"}, {59'd0, exception_cause}, {59'd0, v.cause});
    for (int i = 1; i < v.dly; i++) begin
      cycle();
      check({tag, "_wait_flush"}, {62'd0, flush_req, exception_flag}, 64'd2);
    end
    flush_ack = 1'b1;
    cycle();
    flush_ack = 1'b0;
    check({tag, "_commit"}, {61'd0, exception_flag, flush_req, stall}, 64'd5);
    cycle();
    check({tag, "_idle"}, {61'd0, exception_flag, flush_req, stall}, 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           vld ill ebk ecl mrt tmr mie mtie pc                     dly take cause
    vecs[0] = '{1, 0, 0, 1, 0, 0, 0, 0, 64'h0000_0000_8000_0010, 1, 1, 5'b01011};
    vecs[1] = '{1, 1, 0, 1, 0, 0, 0, 0, 64'h0000_0000_8000_0020, 2, 1, 5'b00010};
    vecs[2] = '{1, 0, 1, 0, 0, 0, 0, 0, 64'h0000_0000_8000_0030, 1, 1, 5'b00011};
    vecs[3] = '{1, 0, 0, 0, 1, 0, 0, 0, 64'hffff_ffff_ffff_fffc, 1, 1, 5'b11111};
    vecs[4] = '{1, 1, 1, 1, 1, 1, 1, 1, 64'h0000_0000_8000_0050, 1, 1, 5'b10111};
    vecs[5] = '{1, 0, 0, 0, 1, 1, 0, 1, 64'h0000_0000_8000_0060, 1, 1, 5'b11111};
    vecs[6] = '{1, 0, 0, 0, 0, 1, 1, 0, 64'h0000_0000_8000_0070, 1, 0, 5'b00000};
    vecs[7] = '{1, 0, 0, 0, 0, 1, 1, 1, 64'h0000_0000_8000_0080, 3, 1, 5'b10111};
    vecs[8] = '{0, 1, 0, 1, 0, 0, 0, 0, 64'h0000_0000_8000_0090, 1, 0, 5'b00000};
    vecs[9] = '{1, 0, 1, 1, 1, 0, 0, 0, 64'h0000_0000_8000_00a0, 4, 1, 5'b00011};

    clear_inputs();
    inst_pc   = 64'd0;
    tmr_wen   = 1'b0;
    tmr_wdata = 64'd0;
    flush_ack = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {61'd0, exception_flag, flush_req, stall}, 64'd0);
    check("rst_cause", {59'd0, exception_cause}, 64'd0);
    check("rst_epc", epc, 64'd0);
    check("rst_mtip", {63'd0, mtip}, 64'd0);
    rst = 1'b0;
    // Stray ack in IDLE must not start anything.
    flush_ack = 1'b1;
    cycle();
    flush_ack = 1'b0;
    check("idle_ack_ignored", {61'd0, exception_flag, flush_req, stall}, 64'd0);

    foreach (vecs[i]) begin
`ifdef TIMER_IRQ_EN
      if (vecs[i].tmr) continue;
`endif
      apply_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Long wait for ack while further commits try to trap.
    begin
      vec_t v;
      v = '{1, 0, 0, 1, 0, 0, 0, 0, 64'h0000_0000_1234_5678, 1, 1, 5'b01011};
      inst_valid = 1'b1; exc_ecall = 1'b1; inst_pc = v.pc;
      sbq.push_back('{cause: v.cause, pc: v.pc});
      cycle();
      for (int i = 0; i < 10; i++) begin
        inst_valid = 1'b1; exc_illegal = 1'b1; exc_ecall = 1'b1;
        inst_pc = 64'h0000_0000_0bad_0000 + 64'(i);
        check("wait_flush_stall", {62'd0, flush_req, stall}, 64'd3);
        check("wait_no_flag", {63'd0, exception_flag}, 64'd0);
        check("wait_epc_held", epc, v.pc);
        cycle();
      end
      clear_inputs();
      flush_ack = 1'b1;
      cycle();
      flush_ack = 1'b0;
      check("wait_commit", {61'd0, exception_flag, flush_req, stall}, 64'd5);
      cycle();
      check("wait_idle", {61'd0, exception_flag, flush_req, stall}, 64'd0);
    end

    // Reset in FLUSH aborts the trap; ack alongside reset must not leak through.
    inst_valid = 1'b1; exc_ebreak = 1'b1; inst_pc = 64'h0000_0000_7777_0000;
    cycle();
    clear_inputs();
    check("abort_in_flush", {63'd0, flush_req}, 64'd1);
    rst = 1'b1; flush_ack = 1'b1;
    cycle();
    check("abort_ctrl", {61'd0, exception_flag, flush_req, stall}, 64'd0);
    check("abort_cause", {59'd0, exception_cause}, 64'd0);
    check("abort_epc", epc, 64'd0);
    rst = 1'b0;
    cycle();
    flush_ack = 1'b0;
    repeat (3) begin
      check("abort_no_flag", {62'd0, exception_flag, stall}, 64'd0);
      cycle();
    end

`ifdef TIMER_IRQ_EN
    begin
      vec_t v;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      tmr_wen = 1'b1; tmr_wdata = 64'd20;
      cycle();
      tmr_wen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (mtip) break;
        cycle();
      end
      check("mtip_rise_at", model_mtime, 64'd20);
      v = '{1, 0, 0, 0, 1, 0, 0, 1, 64'h0000_0000_8000_0100, 1, 1, 5'b11111};
      apply_vec(v, "tmr_masked_mret");
      v = '{1, 0, 0, 0, 0, 0, 1, 1, 64'h0000_0000_8000_0200, 2, 1, 5'b10111};
      apply_vec(v, "tmr_take");
      tmr_wen = 1'b1; tmr_wdata = {64{1'b1}};
      cycle();
      tmr_wen = 1'b0;
      check("mtip_cleared", {63'd0, mtip}, 64'd0);
    end
`endif

    cycle();
    check("sb_drained", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock for all state.
REQ-002 SHALL have port rst  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-003 SHALL have port inst_valid  input  1  commit-stage instruction valid this cycle.
REQ-004 SHALL have port inst_pc  input  64  PC of the commit-stage instruction.
REQ-005 SHALL have ports exc_illegal, exc_ebreak, exc_ecall, exc_mret  input  1 each  commit-stage trap decodes, qualified by inst_valid.
REQ-006 SHALL have ports mstatus_mie, mie_mtie  input  1 each  global and timer interrupt enables from the CSR file.
REQ-007 SHALL have port ext_timer_irq  input  1  external timer pending (used only without TIMER_IRQ_EN).
REQ-008 SHALL have ports tmr_wen  input  1, tmr_wdata  input  64  mtimecmp write strobe and data.
REQ-009 SHALL have port flush_ack  input  1  pipeline reports front stages flushed.
REQ-010 SHALL have port flush_req  output  1  request pipeline flush.
REQ-011 SHALL have port stall  output  1  block new commits while a trap is in flight.
REQ-012 SHALL have ports exception_flag  output  1, exception_cause  output  5, epc  output  64  trap request into the CSR file.
REQ-013 SHALL have port mtip  output  1  current timer-pending level.

Function
REQ-014 SHALL encode exception_cause as {interrupt bit, 4-bit code}: timer 5'b10111, illegal 5'b00010, ebreak 5'b00011, ecall 5'b01011, mret 5'b11111 (value of `MRET).
REQ-015 SHALL detect an event in IDLE when inst_valid=1 and (any exc_* = 1 or (mtip & mstatus_mie & mie_mtie)).
REQ-016 SHALL resolve simultaneous sources by priority timer > illegal > ebreak > ecall > mret; only the winner is recorded.
REQ-017 SHALL register cause and epc=inst_pc in the detect cycle; epc and exception_cause SHALL hold stable until return to IDLE.
REQ-018 SHALL implement FSM IDLE -> FLUSH (on event) -> COMMIT (on flush_ack in FLUSH) -> IDLE (unconditional after one cycle).
REQ-019 SHALL assert flush_req exactly while in FLUSH; flush_ack outside FLUSH SHALL be ignored.
REQ-020 SHALL assert exception_flag for exactly one cycle, in COMMIT; event at cycle N, flush_ack at cycle M>=N+1 gives exception_flag at M+1 and IDLE at M+2.
REQ-021 SHALL drive stall = (state != IDLE); inst_valid and exc_* outside IDLE SHALL be ignored.
REQ-022 SHALL drive exception_flag=0 and flush_req=0 in IDLE; exception_cause and epc SHALL read 0 until the first event.

Reset
REQ-023 SHALL on rst force state IDLE, flush_req=0, exception_flag=0, stall=0, exception_cause=0, epc=0, in any state, including mid-FLUSH (no exception_flag is ever emitted for an aborted trap).
REQ-024 SHALL on rst clear mtime to 0 and set mtimecmp to all ones (when TIMER_IRQ_EN defined).

Configuration
REQ-025 SHALL with TIMER_IRQ_EN defined contain 64-bit mtime incrementing by 1 every cycle (wrapping at 2^64-1 to 0) and 64-bit mtimecmp loaded from tmr_wdata when tmr_wen=1; mtip = (mtime >= mtimecmp), unsigned; ext_timer_irq ignored.
REQ-026 SHALL without TIMER_IRQ_EN omit mtime/mtimecmp, ignore tmr_wen/tmr_wdata, and drive mtip = ext_timer_irq.

Verification
REQ-027 ecall at inst_pc=0x8000_0010, flush_ack one cycle later -> flush_req 1 cycle, then exception_flag=1 one cycle, cause=5'b01011, epc=0x8000_0010.
REQ-028 exc_illegal=1 and exc_ecall=1 same cycle, mtip=0 -> cause=5'b00010.
REQ-029 TIMER_IRQ_EN, mtimecmp written 20 after reset, mstatus_mie=mie_mtie=1, inst_valid=1 -> mtip rises when mtime reaches 20; trap taken with cause=5'b10111, epc=that cycle's inst_pc.
REQ-030 mtip=1 with mstatus_mie=0 plus exc_mret=1 -> cause=5'b11111; interrupt not taken.
REQ-031 flush_ack held low 10 cycles -> flush_req and stall stay 1, exception_flag stays 0; new ecall during wait ignored; ack then gives single exception_flag.
REQ-032 rst asserted in FLUSH -> next cycle IDLE, all outputs 0, no exception_flag afterward.
